multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  Multi-cycle RV32I execution core. Successor to the single-cycle datapath.
//  Sequences FETCH/DECODE/EXEC/MEM/WB with an internal FSM and talks to external
//  instruction/data memories over req/ready handshakes, so memories may stall.
//  Adds byte/halfword loads and stores, an RV32E register-count option and a sticky trap/halt.
//  The external decoder still drives the control inputs, combinationally from the instr output.
// PARAMETERS
//  ADDR_WIDTH  32    byte-address width on both memory ports (12..32)
//  RESET_PC    32'h0 PC value loaded on reset
//  NUM_REGS    32    register count: 32 (RV32I) or 16 (RV32E)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset (0 = in reset)
//  opcode,rd,funct3,rs1,rs2,funct7  in  7/5/3/5/5/7  decoded fields of instr
//  alu_ctrl,imm_out,reg_write,mem_read,mem_write,alu_src,op1_sel,wb_sel  in  as single-cycle datapath
//  is_branch,is_jal,is_jalr  in  1 each  control-flow class
//  illegal      in   1   decoder flags the current instr as unsupported
//  imem_req     out  1   fetch request
//  imem_addr    out  ADDR_WIDTH  fetch byte address (= PC)
//  imem_ready   in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  dmem_req     out  1   data request
//  dmem_we      out  1   1 = store, 0 = load
//  dmem_addr    out  ADDR_WIDTH  word-aligned byte address (low 2 bits = 0)
//  dmem_wdata   out  32  store data, lane-replicated
//  dmem_wstrb   out  4   byte-lane enables (all 0 for loads)
//  dmem_ready   in   1   data access complete; dmem_rdata valid for loads
//  dmem_rdata   in   32  load word
//  instr        out  32  instruction register (IR)
//  debug_pc     out  32  PC of the instruction in flight
//  retire       out  1   1-cycle pulse when an instruction commits
//  trap         out  1   sticky; core halted
// BEHAVIOUR
//  Reset (reset=0, async): state=FETCH, PC=RESET_PC, IR=32'h00000013 (NOP).
//   All req/we/wstrb/retire/trap = 0. Regs x1..xN-1 = 0.
//   Reset mid-access drops req immediately; the access is abandoned.
//  States: FETCH->DECODE->EXEC->{MEM|WB|FETCH}; MEM->{WB|FETCH}; WB->FETCH; HALT is terminal.
//  FETCH: imem_req=1, imem_addr=PC. On imem_ready: IR<=imem_rdata, go to DECODE.
//   If PC[1:0]!=0: no request, go to HALT.
//  DECODE: latch A<=rs1_data and B<=rs2_data.
//   Go to HALT if any of: illegal; NUM_REGS=16 and rs1/rs2/rd >= 16; mem_read&mem_write.
//  EXEC: ALUOut<=alu(op_a,op_b). op_a/op_b selected as op1_sel/alu_src.
//   Branch: PC<=taken?PC+imm:PC+4, retire, go to FETCH.
//   Loads/stores go to MEM. All others go to WB.
//  MEM: dmem_addr={ALUOut[A-1:2],2'b00}.
//   Misalign goes to HALT with no request: LH/LHU/SH with ALUOut[0]=1; LW/SW with ALUOut[1:0]!=0.
//   Store: wstrb from funct3/ALUOut[1:0] (SB 0001<<a, SH 0011<<a, SW 1111).
//    wdata = B replicated (byte x4, half x2).
//    On dmem_ready: PC<=PC+4, retire, go to FETCH.
//   Load: on dmem_ready latch MDR <= selected lane.
//    LB/LH sign-extend; LBU/LHU zero-extend. Go to WB.
//  WB: rd<=wb_sel (ALU/MEM/PC+4) unless rd==0.
//   Next PC: jal->PC+imm; jalr->(A+imm)&~1; else PC+4. Retire.
//  Handshake: once req=1, addr/we/wdata/wstrb are held stable until the ready cycle.
//   req drops the cycle after ready. ready while req=0 is ignored.
//  Latency (zero-wait memory): ALU/jal/jalr 4 cycles, load 5, store 4, branch 3.
//   Each ready wait-cycle adds 1.
//  HALT: trap=1; no req; PC and IR frozen. Only reset exits.
//  PC arithmetic is modulo 2^32; imem_addr/dmem_addr take the low ADDR_WIDTH bits.
// TESTING
//  1 Reset with RESET_PC=0x100, imem_ready=1 -> imem_addr=0x100 in the first cycle; retire every 4 cycles for ADDI.
//  2 ADDI x1,x0,5; ADD x2,x1,x1, with imem_ready delayed 3 cycles -> x2=10; each retire slips 3 cycles.
//  3 x1=0x80: SB x2(=0xAB) at 0x83 -> wstrb=1000, wdata=0xABABABAB.
//    Then LB from 0x83 -> 0xFFFFFFAB; LBU -> 0x000000AB.
//  4 BEQ taken, imm=-8, from PC=0x20 -> next fetch at 0x18, 3 cycles.
//    JALR rs1=0x41, imm=0 -> PC=0x40 and rd=old PC+4.
//  5 LW at 0x102 -> no dmem_req, trap=1 sticky. Async reset clears trap and restarts at RESET_PC.
//  6 NUM_REGS=16, ADD x20,x1,x2 -> HALT. ADDI x0,x0,1 -> x0 stays 0 and retire pulses.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencer with req/ready memory ports.
// alu_ctrl: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLL 6 SRL 7 SRA 8 SLT 9 SLTU 10 pass-B; op1_sel: 0 rs1 1 PC 2 zero; wb_sel: 0 ALU 1 MEM 2 PC+4.
module multicycle_datapath #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [2:0]            funct3,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [6:0]            funct7,
  input  logic [3:0]            alu_ctrl,
  input  logic [31:0]           imm_out,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  alu_src,
  input  logic [1:0]            op1_sel,
  input  logic [1:0]            wb_sel,
  input  logic                  is_branch,
  input  logic                  is_jal,
  input  logic                  is_jalr,
  input  logic                  illegal,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ready,
  input  logic [31:0]           dmem_rdata,
  output logic [31:0]           instr,
  output logic [31:0]           debug_pc,
  output logic                  retire,
  output logic                  trap
);

  localparam int unsigned RIDX = (NUM_REGS > 16) ? 5 : 4;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic        retire_q, retire_d, trap_q, trap_d;
  logic [31:0] regs_q [NUM_REGS];

  logic [31:0] rs1_data, rs2_data, op_a, op_b, alu_res, pc_plus4, rf_wdata, ld_word, ld_val;
  logic [31:0] st_wdata;
  logic [3:0]  st_strb;
  logic        rf_we, taken, bad_reg, misalign, mem_go;
  logic        unused_fields;

  assign unused_fields = ^{opcode, funct7};

  assign rs1_data = regs_q[rs1[RIDX-1:0]];
  assign rs2_data = regs_q[rs2[RIDX-1:0]];
  assign pc_plus4 = pc_q + 32'd4;
  assign bad_reg  = (NUM_REGS == 16) && (rs1[4] || rs2[4] || rd[4]);

  assign misalign = ((funct3[1:0] == 2'b01) && alu_q[0]) ||
                    ((funct3[1:0] == 2'b10) && (alu_q[1:0] != 2'b00));
  assign mem_go   = (state_q == S_MEM) && !misalign;

  // reset gates the requests directly so an access in flight is dropped at once
  assign imem_req   = reset && (state_q == S_FETCH) && (pc_q[1:0] == 2'b00);
  assign imem_addr  = pc_q[ADDR_WIDTH-1:0];
  assign dmem_req   = reset && mem_go;
  assign dmem_we    = dmem_req && mem_write;
  assign dmem_addr  = {alu_q[ADDR_WIDTH-1:2], 2'b00};
  assign dmem_wdata = st_wdata;
  assign dmem_wstrb = dmem_we ? st_strb : 4'b0000;
  assign instr      = ir_q;
  assign debug_pc   = pc_q;
  assign retire     = retire_q;
  assign trap       = trap_q;

  always_comb begin
    case (op1_sel)
      2'd1:    op_a = pc_q;
      2'd2:    op_a = '0;
      default: op_a = a_q;
    endcase
    op_b = alu_src ? imm_out : b_q;
    case (alu_ctrl)
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << op_b[4:0];
      4'd6:    alu_res = op_a >> op_b[4:0];
      4'd7:    alu_res = $signed(op_a) >>> op_b[4:0];
      4'd8:    alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd9:    alu_res = {31'd0, op_a < op_b};
      4'd10:   alu_res = op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = (a_q == b_q);
      3'b001:  taken = (a_q != b_q);
      3'b100:  taken = $signed(a_q) < $signed(b_q);
      3'b101:  taken = $signed(a_q) >= $signed(b_q);
      3'b110:  taken = a_q < b_q;
      3'b111:  taken = a_q >= b_q;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ld_word = dmem_rdata >> {alu_q[1:0], 3'b000};
    case (funct3)
      3'b000:  ld_val = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b100:  ld_val = {24'd0, ld_word[7:0]};
      3'b001:  ld_val = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b101:  ld_val = {16'd0, ld_word[15:0]};
      default: ld_val = dmem_rdata;
    endcase
    case (funct3[1:0])
      2'b00:   begin st_wdata = {4{b_q[7:0]}};  st_strb = 4'b0001 << alu_q[1:0]; end
      2'b01:   begin st_wdata = {2{b_q[15:0]}}; st_strb = 4'b0011 << alu_q[1:0]; end
      default: begin st_wdata = b_q;            st_strb = 4'b1111; end
    endcase
    case (wb_sel)
      2'd1:    rf_wdata = mdr_q;
      2'd2:    rf_wdata = pc_plus4;
      default: rf_wdata = alu_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (pc_q[1:0] != 2'b00) state_d = S_HALT;
        else if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs1_data;
        b_d     = rs2_data;
        state_d = (illegal || bad_reg || (mem_read && mem_write)) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        if (is_branch) begin
          pc_d     = taken ? pc_q + imm_out : pc_plus4;
          retire_d = 1'b1;
          state_d  = S_FETCH;
        end else if (mem_read || mem_write) state_d = S_MEM;
        else state_d = S_WB;
      end
      S_MEM: begin
        if (misalign) state_d = S_HALT;
        else if (dmem_ready) begin
          if (mem_write) begin
            pc_d     = pc_plus4;
            retire_d = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = ld_val;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we = reg_write && (rd != 5'd0);
        if (is_jal)       pc_d = pc_q + imm_out;
        else if (is_jalr) pc_d = (a_q + imm_out) & ~32'd1;
        else              pc_d = pc_plus4;
        retire_d = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    trap_d = trap_q || (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0000_0013;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      retire_q <= 1'b0;
      trap_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      mdr_q    <= mdr_d;
      retire_q <= retire_d;
      trap_q   <= trap_d;
      if (rf_we) regs_q[rd[RIDX-1:0]] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench: RV32I core (RESET_PC=0x100) plus an RV32E core (RESET_PC=0x200) sharing one program image.
module tb_multicycle_datapath;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;
    logic        reg_write, mem_read, mem_write, alu_src;
    logic [1:0]  op1_sel, wb_sel;
    logic        is_branch, is_jal, is_jalr, illegal;
  } ctrl_t;

  // external decoder: the small RV32I subset used by the program below
  function automatic ctrl_t dec(input logic [31:0] i);
    ctrl_t c;
    c = '0;
    case (i[6:0])
      7'h13: begin c.imm = {{20{i[31]}}, i[31:20]}; c.reg_write = 1; c.alu_src = 1; c.illegal = (i[14:12] != 3'd0); end
      7'h33: begin c.reg_write = 1; c.illegal = (i[14:12] != 3'd0) || (i[31:25] != 7'd0); end
      7'h03: begin c.imm = {{20{i[31]}}, i[31:20]}; c.reg_write = 1; c.mem_read = 1; c.alu_src = 1; c.wb_sel = 2'd1; end
      7'h23: begin c.imm = {{20{i[31]}}, i[31:25], i[11:7]}; c.mem_write = 1; c.alu_src = 1; end
      7'h63: begin c.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; c.is_branch = 1; c.alu_ctrl = 4'd1; end
      7'h6F: begin c.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; c.is_jal = 1; c.reg_write = 1; c.wb_sel = 2'd2; end
      7'h67: begin c.imm = {{20{i[31]}}, i[31:20]}; c.is_jalr = 1; c.reg_write = 1; c.alu_src = 1; c.wb_sel = 2'd2; end
      default: c.illegal = 1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs, input logic [2:0] f3);
    return {imm[11:5], rs2, rs, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs, input logic [4:0] rd);
    return {7'd0, rs2, rs, 3'd0, rd, 7'h33};
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];

  // ---------------- RV32I instance ----------------
  logic        reset;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, trap;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, instr, debug_pc;
  logic [3:0]  dmem_wstrb;
  ctrl_t       c;
  assign c = dec(instr);

  int unsigned imem_delay = 0;
  int unsigned iwait = 0;
  int unsigned dreq_cnt = 0;
  logic [31:0] st_addr = '0, st_wdata = '0;
  logic [3:0]  st_wstrb = '0;

  assign imem_ready = imem_req && (iwait == imem_delay);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_ready = dmem_req;
  assign dmem_rdata = dmem[dmem_addr[9:2]];

  always @(posedge clk) begin
    iwait <= (!imem_req || imem_ready) ? 0 : iwait + 1;
    if (dmem_req) begin
      dreq_cnt <= dreq_cnt + 1;
      if (dmem_we) begin
        st_addr  <= dmem_addr;
        st_wdata <= dmem_wdata;
        st_wstrb <= dmem_wstrb;
        for (int b = 0; b < 4; b++)
          if (dmem_wstrb[b]) dmem[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

  multicycle_datapath #(.ADDR_WIDTH(32), .RESET_PC(32'h100), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset),
    .opcode(instr[6:0]), .rd(instr[11:7]), .funct3(instr[14:12]), .rs1(instr[19:15]),
    .rs2(instr[24:20]), .funct7(instr[31:25]),
    .alu_ctrl(c.alu_ctrl), .imm_out(c.imm), .reg_write(c.reg_write), .mem_read(c.mem_read),
    .mem_write(c.mem_write), .alu_src(c.alu_src), .op1_sel(c.op1_sel), .wb_sel(c.wb_sel),
    .is_branch(c.is_branch), .is_jal(c.is_jal), .is_jalr(c.is_jalr), .illegal(c.illegal),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .instr(instr), .debug_pc(debug_pc), .retire(retire), .trap(trap)
  );

  // ---------------- RV32E instance ----------------
  logic        reset_e;
  logic        imem_req_e, dmem_req_e, dmem_we_e, retire_e, trap_e;
  logic [31:0] imem_addr_e, dmem_addr_e, dmem_wdata_e, instr_e, debug_pc_e;
  logic [3:0]  dmem_wstrb_e;
  ctrl_t       ce;
  assign ce = dec(instr_e);
  logic [31:0] st_wdata_e = 32'hDEAD_BEEF;
  logic [3:0]  st_wstrb_e = '0;

  always @(posedge clk) begin
    if (dmem_req_e && dmem_we_e) begin
      st_wdata_e <= dmem_wdata_e;
      st_wstrb_e <= dmem_wstrb_e;
    end
  end

  multicycle_datapath #(.ADDR_WIDTH(32), .RESET_PC(32'h200), .NUM_REGS(16)) dut_e (
    .clk(clk), .reset(reset_e),
    .opcode(instr_e[6:0]), .rd(instr_e[11:7]), .funct3(instr_e[14:12]), .rs1(instr_e[19:15]),
    .rs2(instr_e[24:20]), .funct7(instr_e[31:25]),
    .alu_ctrl(ce.alu_ctrl), .imm_out(ce.imm), .reg_write(ce.reg_write), .mem_read(ce.mem_read),
    .mem_write(ce.mem_write), .alu_src(ce.alu_src), .op1_sel(ce.op1_sel), .wb_sel(ce.wb_sel),
    .is_branch(ce.is_branch), .is_jal(ce.is_jal), .is_jalr(ce.is_jalr), .illegal(ce.illegal),
    .imem_req(imem_req_e), .imem_addr(imem_addr_e), .imem_ready(imem_req_e),
    .imem_rdata(imem[imem_addr_e[9:2]]),
    .dmem_req(dmem_req_e), .dmem_we(dmem_we_e), .dmem_addr(dmem_addr_e), .dmem_wdata(dmem_wdata_e),
    .dmem_wstrb(dmem_wstrb_e), .dmem_ready(dmem_req_e), .dmem_rdata(32'h0),
    .instr(instr_e), .debug_pc(debug_pc_e), .retire(retire_e), .trap(trap_e)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // counts negedges until the chosen event (0 retire, 1 trap, 2 retire_e, 3 trap_e), bounded
  task automatic wait_evt(input string tag, input int sel, input int exp_n);
    int  n;
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = retire;
        1:       hit = trap;
        2:       hit = retire_e;
        default: hit = trap_e;
      endcase
    end while (!hit && n < 40);
    check(tag, n, exp_n);
  endtask

  int unsigned dreq_snap;
  logic [31:0] lw_word;

  initial begin
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
    dmem[32] = 32'h1122_3344;
    imem[64] = enc_i(32'd5, 5'd0, 3'd0, 5'd1, 7'h13);          // 0x100 ADDI x1,x0,5
    imem[65] = enc_r(5'd1, 5'd1, 5'd2);                         // 0x104 ADD x2,x1,x1
    imem[66] = enc_s(32'h40, 5'd2, 5'd0, 3'd2);                 // 0x108 SW x2,0x40(x0)
    imem[67] = enc_i(32'h80, 5'd0, 3'd0, 5'd1, 7'h13);          // 0x10C ADDI x1,x0,0x80
    imem[68] = enc_i(32'hAB, 5'd0, 3'd0, 5'd2, 7'h13);          // 0x110 ADDI x2,x0,0xAB
    imem[69] = enc_s(32'd3, 5'd2, 5'd1, 3'd0);                  // 0x114 SB x2,3(x1)
    imem[70] = enc_i(32'd3, 5'd1, 3'd0, 5'd3, 7'h03);           // 0x118 LB x3,3(x1)
    imem[71] = enc_i(32'd3, 5'd1, 3'd4, 5'd4, 7'h03);           // 0x11C LBU x4,3(x1)
    imem[72] = enc_s(32'h44, 5'd3, 5'd0, 3'd2);                 // 0x120 SW x3,0x44(x0)
    imem[73] = enc_s(32'h48, 5'd4, 5'd0, 3'd2);                 // 0x124 SW x4,0x48(x0)
    imem[74] = enc_j(32'hFFFF_FEF8, 5'd5);                      // 0x128 JAL x5,-0x108 -> 0x20
    imem[8]  = enc_b(32'hFFFF_FFF8, 5'd0, 5'd0, 3'd0);          // 0x20  BEQ x0,x0,-8
    imem[6]  = enc_i(32'h41, 5'd0, 3'd0, 5'd6, 7'h13);          // 0x18  ADDI x6,x0,0x41
    imem[7]  = enc_i(32'd0, 5'd6, 3'd0, 5'd7, 7'h67);           // 0x1C  JALR x7,0(x6)
    imem[16] = enc_b(32'd8, 5'd0, 5'd0, 3'd1);                  // 0x40  BNE x0,x0,+8 (not taken)
    imem[17] = enc_s(32'h4C, 5'd7, 5'd0, 3'd2);                 // 0x44  SW x7,0x4C(x0)
    imem[18] = enc_s(32'h50, 5'd5, 5'd0, 3'd2);                 // 0x48  SW x5,0x50(x0)
    imem[19] = enc_i(32'h102, 5'd0, 3'd0, 5'd8, 7'h13);         // 0x4C  ADDI x8,x0,0x102
    imem[20] = enc_i(32'd0, 5'd8, 3'd2, 5'd9, 7'h03);           // 0x50  LW x9,0(x8)
    imem[128] = enc_i(32'd1, 5'd0, 3'd0, 5'd0, 7'h13);          // 0x200 ADDI x0,x0,1
    imem[129] = enc_s(32'h40, 5'd0, 5'd0, 3'd2);                // 0x204 SW x0,0x40(x0)
    imem[130] = enc_r(5'd2, 5'd1, 5'd20);                       // 0x208 ADD x20,x1,x2
    lw_word = imem[20];

    reset = 1'b0;
    reset_e = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_retire", retire, 0);
    check("rst_trap", trap, 0);
    check("rst_ir", instr, 32'h13);
    check("rst_pc", debug_pc, 32'h100);

    reset = 1'b1;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h100);
    wait_evt("addi_lat", 0, 4);
    imem_delay = 3;
    @(negedge clk);
    check("retire_pulse", retire, 0);
    wait_evt("add_slow_lat", 0, 6);
    imem_delay = 0;
    wait_evt("sw_lat", 0, 4);
    check("sw_addr", st_addr, 32'h40);
    check("sw_data_x2", st_wdata, 32'd10);
    check("sw_strb", st_wstrb, 4'hF);

    wait_evt("addi_x1", 0, 4);
    wait_evt("addi_x2", 0, 4);
    wait_evt("sb_lat", 0, 4);
    check("sb_addr", st_addr, 32'h80);
    check("sb_strb", st_wstrb, 4'b1000);
    check("sb_data", st_wdata, 32'hABAB_ABAB);
    check("sb_mem", dmem[32], 32'hAB22_3344);
    wait_evt("lb_lat", 0, 5);
    wait_evt("lbu_lat", 0, 5);
    wait_evt("sw_x3", 0, 4);
    check("lb_val", st_wdata, 32'hFFFF_FFAB);
    wait_evt("sw_x4", 0, 4);
    check("lbu_val", st_wdata, 32'h0000_00AB);

    wait_evt("jal_lat", 0, 4);
    check("jal_pc", debug_pc, 32'h20);
    wait_evt("beq_lat", 0, 3);
    check("beq_pc", debug_pc, 32'h18);
    wait_evt("addi_x6", 0, 4);
    wait_evt("jalr_lat", 0, 4);
    check("jalr_pc", debug_pc, 32'h40);
    wait_evt("bne_lat", 0, 3);
    check("bne_pc", debug_pc, 32'h44);
    wait_evt("sw_x7", 0, 4);
    check("jalr_link", st_wdata, 32'h20);
    wait_evt("sw_x5", 0, 4);
    check("jal_link", st_wdata, 32'h12C);

    wait_evt("addi_x8", 0, 4);
    dreq_snap = dreq_cnt;
    wait_evt("lw_mis_trap", 1, 4);
    check("lw_mis_noreq", dreq_cnt, dreq_snap);
    repeat (5) @(negedge clk);
    check("halt_trap_sticky", trap, 1);
    check("halt_no_ireq", imem_req, 0);
    check("halt_pc", debug_pc, 32'h50);
    check("halt_ir", instr, lw_word);
    check("halt_no_retire", retire, 0);

    #2 reset = 1'b0;
    #1;
    check("areset_trap", trap, 0);
    check("areset_pc", debug_pc, 32'h100);
    check("areset_ir", instr, 32'h13);
    @(negedge clk);
    imem_delay = 3;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_req", imem_req, 1);
    check("stall_ready", imem_ready, 0);
    #2 reset = 1'b0;
    #1;
    check("midaccess_drop", imem_req, 0);
    @(negedge clk);
    imem_delay = 0;
    reset = 1'b1;
    wait_evt("restart_lat", 0, 4);
    check("restart_pc", debug_pc, 32'h104);

    reset_e = 1'b1;
    wait_evt("e_addi_x0_retire", 2, 4);
    wait_evt("e_sw_lat", 2, 4);
    check("e_x0_zero", st_wdata_e, 32'h0);
    check("e_sw_strb", st_wstrb_e, 4'hF);
    wait_evt("e_bad_reg_trap", 3, 2);
    check("e_halt_pc", debug_pc_e, 32'h208);
    check("e_no_retire", retire_e, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
